seven_segment_renderer: RTL and testbench

Parametrised multi-digit seven-segment pixel renderer for the VGA path of the 24-game display. For every pixel coordinate it decides whether the pixel lies on a lit segment of one of NUM_DIGITS digits laid out in a row. It adds tear-free digit updates, per-digit blinking, leading-zero blanking and hex glyphs. The output is a registered 2-stage pipeline, with display-enable delayed alongside it.

---
 rtl/seven_segment_renderer_pkg.sv | 66 ++++++
 rtl/seven_segment_renderer_decode.sv | 19 +
 rtl/seven_segment_renderer.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_seven_segment_renderer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_renderer_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment pixel renderer:
//   - SEG_A..SEG_G : bit positions of each segment in a 7-bit mask, with the
//                    vector laid out as {g,f,e,d,c,b,a}.
//   - MASK_x       : lit-segment mask for every nibble value 0..F.
//   - seg7_mask()  : nibble + hex_mode -> 7-bit mask. Values 10..15 render
//                    as A,b,C,d,E,F only when hex_mode is set, and are
//                    blank otherwise.
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] MASK_0 = 7'h3F;
  localparam logic [6:0] MASK_1 = 7'h06;
  localparam logic [6:0] MASK_2 = 7'h5B;
  localparam logic [6:0] MASK_3 = 7'h4F;
  localparam logic [6:0] MASK_4 = 7'h66;
  localparam logic [6:0] MASK_5 = 7'h6D;
  localparam logic [6:0] MASK_6 = 7'h7D;
  localparam logic [6:0] MASK_7 = 7'h07;
  localparam logic [6:0] MASK_8 = 7'h7F;
  localparam logic [6:0] MASK_9 = 7'h6F;
  localparam logic [6:0] MASK_A = 7'h77;
  localparam logic [6:0] MASK_B = 7'h7C;
  localparam logic [6:0] MASK_C = 7'h39;
  localparam logic [6:0] MASK_D = 7'h5E;
  localparam logic [6:0] MASK_E = 7'h79;
  localparam logic [6:0] MASK_F = 7'h71;

  function automatic logic [6:0] seg7_mask(input logic [3:0] nibble,
                                           input logic       hex_mode);
    logic [6:0] m;
    case (nibble)
      4'h0:    m = MASK_0;
      4'h1:    m = MASK_1;
      4'h2:    m = MASK_2;
      4'h3:    m = MASK_3;
      4'h4:    m = MASK_4;
      4'h5:    m = MASK_5;
      4'h6:    m = MASK_6;
      4'h7:    m = MASK_7;
      4'h8:    m = MASK_8;
      4'h9:    m = MASK_9;
      4'hA:    m = MASK_A;
      4'hB:    m = MASK_B;
      4'hC:    m = MASK_C;
      4'hD:    m = MASK_D;
      4'hE:    m = MASK_E;
      default: m = MASK_F;
    endcase
    // Decimal-only displays show nothing for out-of-range values.
    if ((nibble > 4'd9) && !hex_mode) begin
      m = 7'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/seven_segment_renderer_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational glyph decoder: one nibble in, 7-bit segment mask out.
// Ports:
//   nibble   in  4  digit value 0..F
//   hex_mode in  1  1: A..F glyphs for 10..15, 0: blank for 10..15
//   mask     out 7  lit segments, {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] mask
);

  assign mask = seg7_mask(nibble, hex_mode);

endmodule

// File: rtl/seven_segment_renderer.sv
// ---------------------------------------------------------------------------
// seven_segment_renderer
// Decides, per pixel, whether (sx,sy) falls on a lit segment of one of
// NUM_DIGITS seven-segment digits laid out in a row. Digit values are
// double-buffered so the displayed value only changes at frame boundaries.
// Supports per-digit blinking, leading-zero blanking and hex glyphs.
// Two-cycle registered pipeline; de is delayed alongside the pixel.
// Ports:
//   clk          in  1             pixel clock
//   rst_n        in  1             asynchronous active-low reset
//   sx, sy       in  COORD_W       current pixel coordinate
//   de           in  1             pixel is in the active area
//   frame_start  in  1             one-cycle pulse at first pixel of a frame
//   digits       in  4*NUM_DIGITS  nibble per digit, leftmost digit in MSBs
//   digits_load  in  1             capture digits into the pending register
//   blink_en     in  NUM_DIGITS    per-digit blink enable, MSB = leftmost
//   blank_lz     in  1             leading-zero blanking enable
//   hex_mode     in  1             show A..F for values 10..15
//   pixel_on     out 1             pixel lit (registered)
//   de_out       out 1             de delayed by 2 cycles
//   load_pending out 1             a loaded value is waiting for frame_start
// ---------------------------------------------------------------------------
module seven_segment_renderer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int COORD_W      = 10,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int SEG_W        = 80,
  parameter int SEG_H        = 140,
  parameter int THICK        = 20,
  parameter int DIGIT_GAP    = 20,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_W-1:0]      sx,
  input  logic [COORD_W-1:0]      sy,
  input  logic                    de,
  input  logic                    frame_start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    digits_load,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  input  logic                    hex_mode,
  output logic                    pixel_on,
  output logic                    de_out,
  output logic                    load_pending
);

  // One extra bit so that coordinates left of / above a box go negative.
  localparam int SW    = COORD_W + 1;
  localparam int PITCH = SEG_W + DIGIT_GAP;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic signed [SW-1:0] C_ZERO  = '0;
  localparam logic signed [SW-1:0] C_OY    = SW'(ORIGIN_Y);
  localparam logic signed [SW-1:0] C_SEG_W = SW'(SEG_W);
  localparam logic signed [SW-1:0] C_SEG_H = SW'(SEG_H);
  localparam logic signed [SW-1:0] C_THICK = SW'(THICK);
  localparam logic signed [SW-1:0] C_D_LO  = SW'(SEG_H - THICK);
  localparam logic signed [SW-1:0] C_R_LO  = SW'(SEG_W - THICK);
  // Middle band: lower bound starts the lower verticals and g,
  // upper bound ends the upper verticals and g.
  localparam logic signed [SW-1:0] C_G_LO  = SW'((SEG_H - THICK) / 2);
  localparam logic signed [SW-1:0] C_G_HI  = SW'((SEG_H + THICK) / 2);

  // -------------------------------------------------------------------------
  // Digit double-buffer
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    load_pending_q, load_pending_d;

  always_comb begin
    pending_d      = pending_q;
    active_d       = active_q;
    load_pending_d = load_pending_q;
    if (digits_load && frame_start) begin
      // Already at a frame boundary: apply immediately, nothing left pending.
      pending_d      = digits;
      active_d       = digits;
      load_pending_d = 1'b0;
    end else if (digits_load) begin
      // Last load before the boundary wins.
      pending_d      = digits;
      load_pending_d = 1'b1;
    end else if (frame_start && load_pending_q) begin
      active_d       = pending_q;
      load_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      active_q       <= '0;
      load_pending_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      active_q       <= active_d;
      load_pending_q <= load_pending_d;
    end
  end

  // -------------------------------------------------------------------------
  // Blink timer: phase flips every BLINK_FRAMES frame starts.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_hidden_q, phase_hidden_d;

  always_comb begin
    blink_cnt_d    = blink_cnt_q;
    phase_hidden_d = phase_hidden_q;
    if (frame_start) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d    = '0;
        phase_hidden_d = !phase_hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q    <= '0;
      phase_hidden_q <= 1'b0;
    end else begin
      blink_cnt_q    <= blink_cnt_d;
      phase_hidden_q <= phase_hidden_d;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: geometry. Each digit box is range-checked in parallel; the boxes
  // are disjoint so at most one in_box bit is set.
  // -------------------------------------------------------------------------
  logic signed [SW-1:0] sx_s, sy_s, ly;
  logic signed [SW-1:0] lx [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] in_box;
  logic                  row_hit;

  assign sx_s    = $signed({1'b0, sx});
  assign sy_s    = $signed({1'b0, sy});
  assign ly      = sy_s - C_OY;
  assign row_hit = (ly >= C_ZERO) && (ly < C_SEG_H);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_box
    localparam logic signed [SW-1:0] X_OFF = SW'(ORIGIN_X + gi * PITCH);
    assign lx[gi]     = sx_s - X_OFF;
    assign in_box[gi] = (lx[gi] >= C_ZERO) && (lx[gi] < C_SEG_W);
  end

  logic [IDX_W-1:0]     hit_idx_d;
  logic signed [SW-1:0] lx_sel;
  logic                 hit_valid_d;
  logic [6:0]           seg_hit_d;
  logic                 upper_half, lower_half, left_col, right_col;

  always_comb begin
    hit_idx_d = '0;
    lx_sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (in_box[i]) begin
        hit_idx_d = IDX_W'(i);
        lx_sel    = lx[i];
      end
    end
  end

  assign hit_valid_d = row_hit && (|in_box);
  assign upper_half  = ly < C_G_HI;
  assign lower_half  = ly >= C_G_LO;
  assign left_col    = lx_sel < C_THICK;
  assign right_col   = lx_sel >= C_R_LO;

  always_comb begin
    seg_hit_d        = '0;
    seg_hit_d[SEG_A] = ly < C_THICK;
    seg_hit_d[SEG_B] = right_col && upper_half;
    seg_hit_d[SEG_C] = right_col && lower_half;
    seg_hit_d[SEG_D] = ly >= C_D_LO;
    seg_hit_d[SEG_E] = left_col && lower_half;
    seg_hit_d[SEG_F] = left_col && upper_half;
    seg_hit_d[SEG_G] = lower_half && upper_half;
  end

  logic [IDX_W-1:0] s1_idx_q;
  logic             s1_valid_q;
  logic [6:0]       s1_seg_q;
  logic             s1_de_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_seg_q   <= '0;
      s1_de_q    <= 1'b0;
    end else begin
      s1_idx_q   <= hit_idx_d;
      s1_valid_q <= hit_valid_d;
      s1_seg_q   <= seg_hit_d;
      s1_de_q    <= de;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: glyph lookup and qualifiers on the live active value and
  // live blink/blank/hex controls.
  // -------------------------------------------------------------------------
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_prefix;
  logic [NUM_DIGITS-1:0] suppressed;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    // Digit 0 is the leftmost and lives in the MSBs.
    assign nib[gi] = active_q[4*(NUM_DIGITS-1-gi) +: 4];
  end

  // zero_prefix[i]: digits 0..i are all zero.
  always_comb begin
    logic run;
    run         = 1'b1;
    zero_prefix = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      run            = run && (nib[i] == 4'd0);
      zero_prefix[i] = run;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_supp
    logic blanked;
    if (gi == NUM_DIGITS - 1) begin : g_last
      // The rightmost digit always shows, so zero reads as "0".
      assign blanked = 1'b0;
    end else begin : g_lead
      assign blanked = blank_lz && zero_prefix[gi];
    end
    assign suppressed[gi] = blanked ||
                            (blink_en[NUM_DIGITS-1-gi] && phase_hidden_q);
  end

  logic [3:0] sel_nibble;
  logic       sel_suppress;
  logic [6:0] sel_mask;

  always_comb begin
    sel_nibble   = '0;
    sel_suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s1_idx_q == IDX_W'(i)) begin
        sel_nibble   = nib[i];
        sel_suppress = suppressed[i];
      end
    end
  end

  seg7_decode u_decode (
    .nibble   (sel_nibble),
    .hex_mode (hex_mode),
    .mask     (sel_mask)
  );

  logic pixel_on_q, pixel_on_d;
  logic de_out_q, de_out_d;

  assign pixel_on_d = s1_de_q && s1_valid_q && (|(s1_seg_q & sel_mask)) &&
                      !sel_suppress;
  assign de_out_d   = s1_de_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on_q <= 1'b0;
      de_out_q   <= 1'b0;
    end else begin
      pixel_on_q <= pixel_on_d;
      de_out_q   <= de_out_d;
    end
  end

  assign pixel_on     = pixel_on_q;
  assign de_out       = de_out_q;
  assign load_pending = load_pending_q;

endmodule

// File: tb/tb_seven_segment_renderer.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_renderer
// Directed probes with hand-computed expectations, then randomized traffic,
// all cross-checked every cycle against a pixel-level reference model.
// ---------------------------------------------------------------------------
module tb_seven_segment_renderer;

  localparam int N   = 4;
  localparam int CW  = 10;
  localparam int OX  = 0;
  localparam int OY  = 0;
  localparam int W   = 80;
  localparam int H   = 140;
  localparam int T   = 20;
  localparam int GAP = 20;
  localparam int BF  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] sx = '0, sy = '0;
  logic          de = 1'b0, frame_start = 1'b0, digits_load = 1'b0;
  logic          blank_lz = 1'b0, hex_mode = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0]  blink_en = '0;
  logic          pixel_on, de_out, load_pending;

  always #5 clk = ~clk;

  seven_segment_renderer #(
    .NUM_DIGITS(N), .COORD_W(CW), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .SEG_W(W), .SEG_H(H), .THICK(T), .DIGIT_GAP(GAP), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .de(de),
    .frame_start(frame_start), .digits(digits), .digits_load(digits_load),
    .blink_en(blink_en), .blank_lz(blank_lz), .hex_mode(hex_mode),
    .pixel_on(pixel_on), .de_out(de_out), .load_pending(load_pending)
  );

  // ------------------------------------------------------------ model ------
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                             7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E,
                             7'h79, 7'h71};

  // Which digit box contains (x,y), or -1.
  function automatic int digit_at(int x, int y);
    int ly;
    ly = y - OY;
    if (ly < 0 || ly >= H) return -1;
    for (int i = 0; i < N; i++) begin
      int lx;
      lx = x - OX - i * (W + GAP);
      if (lx >= 0 && lx < W) return i;
    end
    return -1;
  endfunction

  // Segments {g,f,e,d,c,b,a} covering (x,y) relative to digit idx.
  function automatic logic [6:0] segs_at(int x, int y, int idx);
    int lx, ly;
    logic [6:0] s;
    if (idx < 0) return 7'h00;
    lx = x - OX - idx * (W + GAP);
    ly = y - OY;
    s[0] = ly < T;
    s[1] = (lx >= W - T) && (ly < (H + T) / 2);
    s[2] = (lx >= W - T) && (ly >= (H - T) / 2);
    s[3] = ly >= H - T;
    s[4] = (lx < T) && (ly >= (H - T) / 2);
    s[5] = (lx < T) && (ly < (H + T) / 2);
    s[6] = (ly >= (H - T) / 2) && (ly < (H + T) / 2);
    return s;
  endfunction

  function automatic logic lit_rule(int idx, logic [6:0] segs, logic pix_de,
                                    logic [4*N-1:0] value, int frames,
                                    logic [N-1:0] blink, logic lz, logic hex);
    logic [3:0] v;
    logic [6:0] m;
    logic       leading;
    if (!pix_de || idx < 0) return 1'b0;
    v = value[4*(N-1-idx) +: 4];
    m = (v > 4'd9 && !hex) ? 7'h00 : glyph[v];
    leading = 1'b1;
    for (int j = 0; j <= idx; j++)
      if (value[4*(N-1-j) +: 4] != 4'd0) leading = 1'b0;
    if (lz && idx < N - 1 && leading) return 1'b0;
    if (blink[N-1-idx] && (((frames / BF) % 2) == 1)) return 1'b0;
    return |(segs & m);
  endfunction

  logic [4*N-1:0] m_active, m_pending;
  logic           m_lp, m_s1_de, m_exp_pix, m_exp_de;
  int             m_fs_count, m_s1_idx;
  logic [6:0]     m_s1_segs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   <= '0;
      m_pending  <= '0;
      m_lp       <= 1'b0;
      m_fs_count <= 0;
      m_s1_idx   <= -1;
      m_s1_segs  <= '0;
      m_s1_de    <= 1'b0;
      m_exp_pix  <= 1'b0;
      m_exp_de   <= 1'b0;
    end else begin
      m_s1_idx  <= digit_at(int'(sx), int'(sy));
      m_s1_segs <= segs_at(int'(sx), int'(sy), digit_at(int'(sx), int'(sy)));
      m_s1_de   <= de;
      m_exp_de  <= m_s1_de;
      m_exp_pix <= lit_rule(m_s1_idx, m_s1_segs, m_s1_de, m_active,
                            m_fs_count, blink_en, blank_lz, hex_mode);
      if (frame_start) m_fs_count <= m_fs_count + 1;
      if (digits_load && frame_start) begin
        m_active <= digits;
        m_lp     <= 1'b0;
      end else if (digits_load) begin
        m_pending <= digits;
        m_lp      <= 1'b1;
      end else if (frame_start && m_lp) begin
        m_active <= m_pending;
        m_lp     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------- checking -----
  int          n_checks = 0;
  int          n_pass = 0;
  logic        run_cmp = 1'b0;
  int          req_id = 0;
  int          done_id = 0;
  string       req_name = "";
  logic [7:0]  req_act = '0, req_exp = '0;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Sole writer of the counters: per-cycle model compare plus posted probes.
  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      chk("pixel_on", {7'b0, pixel_on}, {7'b0, m_exp_pix});
      chk("de_out", {7'b0, de_out}, {7'b0, m_exp_de});
      chk("load_pending", {7'b0, load_pending}, {7'b0, m_lp});
    end
    if (req_id != done_id) begin
      chk(req_name, req_act, req_exp);
      done_id = req_id;
    end
  end

  task automatic post(string name, logic [7:0] act, logic [7:0] exp);
    req_name = name;
    req_act  = act;
    req_exp  = exp;
    req_id++;
  endtask

  // ---------------------------------------------------------- stimulus -----
  task automatic probe(string name, int x, int y, logic exp);
    @(negedge clk);
    sx = CW'(x);
    sy = CW'(y);
    de = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("probe %s (%0d,%0d) pixel_on=%0b expect=%0b", name, x, y, pixel_on, exp);
    post(name, {7'b0, pixel_on}, {7'b0, exp});
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic load(logic [4*N-1:0] v);
    @(negedge clk); digits = v; digits_load = 1'b1;
    @(negedge clk); digits_load = 1'b0;
  endtask

  task automatic load_fs(logic [4*N-1:0] v);
    @(negedge clk); digits = v; digits_load = 1'b1; frame_start = 1'b1;
    @(negedge clk); digits_load = 1'b0; frame_start = 1'b0;
  endtask

  task automatic sync_reset_pulse();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);
    #1 post("reset_outputs", {5'b0, pixel_on, de_out, load_pending}, 8'h00);

    // 1: basic geometry on "8888"
    load(16'h8888);
    #1 post("lp_after_load", {7'b0, load_pending}, 8'h01);
    pulse_fs();
    probe("g_lit", 40, 70, 1'b1);
    probe("hollow", 40, 40, 1'b0);
    probe("gap", 90, 70, 1'b0);
    probe("outside_row", 400, 70, 1'b0);

    // 2: tear-free update
    load(16'h1111);
    probe("old_value_held", 10, 10, 1'b1);
    post("lp_mid_frame", {7'b0, load_pending}, 8'h01);
    pulse_fs();
    probe("new_value_af", 10, 10, 1'b0);
    probe("new_value_b", 70, 10, 1'b1);
    load_fs(16'h2222);
    #1 post("lp_coincident", {7'b0, load_pending}, 8'h00);

    // 3: leading-zero blanking
    blank_lz = 1'b1;
    load_fs(16'h0007);
    probe("lz_blank_d0", 10, 10, 1'b0);
    probe("lz_seven_a", 350, 5, 1'b1);
    load_fs(16'h0000);
    probe("lz_zero_no_g", 350, 70, 1'b0);
    probe("lz_zero_f", 305, 70, 1'b1);
    probe("lz_zero_d0", 5, 70, 1'b0);
    blank_lz = 1'b0;

    // 4: hex glyphs
    load_fs(16'h000A);
    hex_mode = 1'b0;
    probe("dec_A_a", 350, 5, 1'b0);
    probe("dec_A_e", 305, 100, 1'b0);
    hex_mode = 1'b1;
    probe("hex_A_a", 350, 5, 1'b1);
    probe("hex_A_no_d", 350, 135, 1'b0);
    hex_mode = 1'b0;

    // 5: blinking, BLINK_FRAMES=2; load with the first frame start
    sync_reset_pulse();
    blink_en = 4'b1000;
    load_fs(16'h8888);
    probe("blink_f1", 40, 70, 1'b1);
    probe("steady_f1", 140, 70, 1'b1);
    pulse_fs();
    probe("blink_f2", 40, 70, 1'b0);
    pulse_fs();
    probe("blink_f3", 40, 70, 1'b0);
    probe("steady_f3", 140, 70, 1'b1);
    pulse_fs();
    probe("blink_f4", 40, 70, 1'b1);
    blink_en = '0;

    // Randomized traffic, checked only by the model
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] d;
      @(negedge clk);
      sx          = CW'($urandom_range(0, 460));
      sy          = CW'($urandom_range(0, 170));
      de          = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 39) == 0);
      digits_load = ($urandom_range(0, 29) == 0);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) d[7:4] = 4'h0;
      digits = d;
      if ($urandom_range(0, 49) == 0) blink_en = N'($urandom);
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 19) == 0) hex_mode = ~hex_mode;
    end
    @(negedge clk);
    frame_start = 1'b0; digits_load = 1'b0;
    blink_en = '0; blank_lz = 1'b0; hex_mode = 1'b0;

    // 6: asynchronous reset mid-line
    load_fs(16'h8888);
    probe("pre_reset_lit", 40, 70, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 post("async_reset_out", {6'b0, pixel_on, de_out}, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    blink_en = 4'hF;
    probe("post_reset_zero_d0", 5, 70, 1'b1);
    probe("post_reset_zero_d3", 305, 70, 1'b1);
    probe("post_reset_no_g", 40, 70, 1'b0);
    post("post_reset_lp", {7'b0, load_pending}, 8'h00);
    @(negedge clk);
    de = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
